// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI transmitter init sequencer:
// FSM states, table markers and the 16-bit {reg, data} table entry.
package hdmi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_DELAY   = 3'd4,
    S_BACKOFF = 3'd5,
    S_FINISH  = 3'd6,
    S_FAIL    = 3'd7
  } state_e;

  localparam logic [7:0] END_MARK   = 8'hFE;
  localparam logic [7:0] DELAY_MARK = 8'hFF;

  typedef struct packed {
    logic [7:0] regaddr;
    logic [7:0] data;
  } entry_t;

  // Tables are passed as a flat vector, entry i at bits [16*i +: 16].
  localparam int MAX_ENTRIES = 256;

  // Typical ADV7513-style bring-up: power up, fixed registers, RGB 4:4:4 in/out.
  localparam logic [MAX_ENTRIES*16-1:0] DEFAULT_TABLE = {
    {(MAX_ENTRIES-13){16'h0000}},
    16'hFE00, 16'hAF06, 16'h1630, 16'h1500, 16'hF900, 16'hE0D0,
    16'hA3A4, 16'hA2A4, 16'h9D61, 16'h9C30, 16'h9AE0, 16'h9803,
    16'h4110
  };

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Combinational index-to-entry lookup into the init table. Indices past
// N_ENTRIES read back as an end marker.
module hdmi_cfg_rom
  import hdmi_pkg::*;
#(
  parameter int                         N_ENTRIES = 32,
  parameter logic [MAX_ENTRIES*16-1:0]  TABLE     = DEFAULT_TABLE
) (
  input  logic [7:0] i_idx,
  output entry_t     o_entry
);

  always_comb begin
    o_entry = '{regaddr: END_MARK, data: 8'h00};
    if (int'(i_idx) < N_ENTRIES) begin
      o_entry = TABLE[{i_idx, 4'h0} +: 16];
    end
  end

endmodule

// File: rtl/hdmi_i2c_seq.sv
// HDMI transmitter init sequencer: walks a register table and issues I2C writes
// through a byte-level master, with per-entry retry/back-off and delay entries.
module hdmi_i2c_seq
  import hdmi_pkg::*;
#(
  parameter logic [6:0]                 DEV_ADDR   = 7'h39,
  parameter int                         N_ENTRIES  = 32,
  parameter int                         MAX_RETRY  = 3,
  parameter int                         DELAY_UNIT = 1024,
  parameter int                         BACKOFF    = 256,
  parameter logic [MAX_ENTRIES*16-1:0]  TABLE      = DEFAULT_TABLE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  output logic       m_req,
  output logic [6:0] m_dev,
  output logic [7:0] m_reg,
  output logic [7:0] m_data,
  input  logic       m_ready,
  input  logic       m_done,
  input  logic       m_nack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] err_idx,
  output state_e     dbg_state
);

  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int CNT_MAX = (DLY_MAX > BACKOFF) ? DLY_MAX : BACKOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           r_state, w_state_nxt;
  logic [8:0]       r_idx;
  logic [3:0]       r_retry;
  logic [3:0]       w_retry_inc;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_reg, r_data, r_err_idx;
  logic             r_done, r_err;
  logic             w_in_range;
  logic             w_req, w_busy;
  entry_t           w_entry;

  hdmi_cfg_rom #(
    .N_ENTRIES (N_ENTRIES),
    .TABLE     (TABLE)
  ) u_rom (
    .i_idx   (r_idx[7:0]),
    .o_entry (w_entry)
  );

  assign w_in_range  = (int'(r_idx) < N_ENTRIES);
  assign w_retry_inc = r_retry + 4'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A NACK wins over a simultaneous done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (!w_in_range || w_entry.regaddr == END_MARK) w_state_nxt = S_FINISH;
        else if (w_entry.regaddr == DELAY_MARK)         w_state_nxt = S_DELAY;
        else                                            w_state_nxt = S_ISSUE;
      end
      S_ISSUE:   if (m_ready) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (m_nack) w_state_nxt = (int'(w_retry_inc) < MAX_RETRY) ? S_BACKOFF : S_FAIL;
        else if (m_done) w_state_nxt = S_FETCH;
      end
      S_DELAY:   if (r_cnt == '0) w_state_nxt = S_FETCH;
      S_BACKOFF: if (r_cnt == '0) w_state_nxt = S_ISSUE;
      S_FINISH:  w_state_nxt = S_IDLE;
      S_FAIL:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // m_req/m_ready: m_req rises with m_dev/m_reg/m_data already valid, is never
  // withdrawn, and the write is accepted on the first clock where both are high;
  // the fields then hold until m_done or m_nack.
  always_comb begin
    w_req  = 1'b0;
    w_busy = 1'b0;
    if (r_state == S_ISSUE) w_req = 1'b1;
    if (r_state != S_IDLE)  w_busy = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx     <= '0;
      r_retry   <= '0;
      r_cnt     <= '0;
      r_reg     <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_idx     <= '0;
          end
        end
        S_FETCH: begin
          if (w_in_range && w_entry.regaddr == DELAY_MARK) begin
            r_cnt <= CNT_W'(int'(w_entry.data) * DELAY_UNIT);
          end else if (w_in_range && w_entry.regaddr != END_MARK) begin
            r_retry <= '0;
            r_reg   <= w_entry.regaddr;
            r_data  <= w_entry.data;
          end
        end
        S_WAIT: begin
          if (m_nack) begin
            r_retry <= w_retry_inc;
            if (int'(w_retry_inc) < MAX_RETRY) r_cnt <= CNT_W'(BACKOFF - 1);
            else                               r_err_idx <= r_idx[7:0];
          end else if (m_done) begin
            r_idx <= r_idx + 9'd1;
          end
        end
        S_DELAY: begin
          if (r_cnt == '0) r_idx <= r_idx + 9'd1;
          else             r_cnt <= r_cnt - CNT_W'(1);
        end
        S_BACKOFF: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FINISH: r_done <= 1'b1;
        S_FAIL:   r_err  <= 1'b1;
        default: ;
      endcase
    end
  end

  assign m_req     = w_req;
  assign m_dev     = DEV_ADDR;
  assign m_reg     = r_reg;
  assign m_data    = r_data;
  assign busy      = w_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_idx   = r_err_idx;
  assign dbg_state = r_state;

endmodule
